// File: rtl/mouse_receiver_if.sv
// Receiver-control port between the PS/2 receive stage and the mouse master FSM.
// The master grants reception; the receiver returns one strobed byte and error code per frame.
interface mouse_receiver_if;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;
  logic       BYTE_READY;

  modport master (
    output READ_ENABLE,
    input  BYTE_READ,
    input  BYTE_ERROR_CODE,
    input  BYTE_READY
  );

  modport slave (
    input  READ_ENABLE,
    output BYTE_READ,
    output BYTE_ERROR_CODE,
    output BYTE_READY
  );
endinterface

// File: rtl/mouse_receiver.sv
// PS/2 receive stage: synchronises the pad clock/data and deserialises 11-bit frames.
// Each frame yields a byte, a {stop_err, parity_err} code and a one-cycle ready strobe.
module mouse_receiver #(
  parameter int TIMEOUT = 50000
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CLK_MOUSE_IN,
  input  logic             DATA_MOUSE_IN,
  mouse_receiver_if.slave  rx
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic          clk_meta_q, clk_sync_q, clk_prev_q;
  logic          data_meta_q, data_sync_q;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [CW-1:0] timer_q, timer_d;
  logic [7:0]    byte_q, byte_d;
  logic [1:0]    err_q, err_d;
  logic          ready_q, ready_d;

  logic fe;
  logic timeout_hit;

  assign fe          = clk_prev_q & ~clk_sync_q;
  assign timeout_hit = (timer_q == CW'(TIMEOUT - 1));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      clk_meta_q  <= 1'b0;
      clk_sync_q  <= 1'b0;
      clk_prev_q  <= 1'b0;
      data_meta_q <= 1'b0;
      data_sync_q <= 1'b0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      timer_q     <= '0;
      byte_q      <= '0;
      err_q       <= '0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_meta_q  <= CLK_MOUSE_IN;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= DATA_MOUSE_IN;
      data_sync_q <= data_meta_q;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      timer_q     <= timer_d;
      byte_q      <= byte_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
    end
  end

  // Outputs are loaded on the stop-bit edge so they are already registered during DONE.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    timer_d   = fe ? '0 : timer_q + CW'(1);
    byte_d    = byte_q;
    err_d     = err_q;
    ready_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (fe && rx.READ_ENABLE && !data_sync_q) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (fe) begin
          shift_d[bit_cnt_q] = data_sync_q;
          bit_cnt_d          = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_PARITY;
          end
        end else if (timeout_hit) begin
          state_d = S_IDLE;
        end
      end
      S_PARITY: begin
        if (fe) begin
          parity_d = data_sync_q;
          state_d  = S_STOP;
        end else if (timeout_hit) begin
          state_d = S_IDLE;
        end
      end
      S_STOP: begin
        if (fe) begin
          state_d = S_DONE;
          byte_d  = shift_q;
          err_d   = {~data_sync_q, ~(^shift_q ^ parity_q)};
          ready_d = 1'b1;
        end else if (timeout_hit) begin
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rx.BYTE_READ       = byte_q;
  assign rx.BYTE_ERROR_CODE = err_q;
  assign rx.BYTE_READY      = ready_q;

endmodule

// File: tb/tb_mouse_receiver.sv
// Scoreboard bench for mouse_receiver: stimulus pushes expected {byte, error} per frame,
// a negedge monitor pops and compares on every BYTE_READY strobe.
module tb_mouse_receiver;

  localparam int TIMEOUT = 200;
  localparam int HALF    = 20;

  logic clk      = 1'b0;
  logic rst      = 1'b0;
  logic ps2_clk  = 1'b1;
  logic ps2_data = 1'b1;

  always #5 clk = ~clk;

  mouse_receiver_if rx_if ();

  mouse_receiver #(.TIMEOUT(TIMEOUT)) dut (
    .CLK           (clk),
    .RESET         (rst),
    .CLK_MOUSE_IN  (ps2_clk),
    .DATA_MOUSE_IN (ps2_data),
    .rx            (rx_if)
  );

  typedef struct packed {
    logic [7:0] b;
    logic [1:0] e;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_item;
  int   checks   = 0;
  int   failures = 0;
  logic prev_ready = 1'b0;

  // Reference rules: odd parity over data+parity bit, stop bit must be 1.
  function automatic logic [1:0] model_err(input logic [7:0] d, input logic par, input logic stp);
    int ones;
    ones = $countones(d) + int'(par);
    model_err = {(stp == 1'b0), (ones % 2 == 0)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_cycles(HALF);
    ps2_clk = 1'b0;
    wait_cycles(HALF);
    ps2_clk = 1'b1;
  endtask

  // Sends the first nbits of a frame; READ_ENABLE is re_start for the start bit, re_rest after.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input int nbits, input logic re_start, input logic re_rest);
    logic [10:0] bits;
    bits = {stp, par, d, 1'b0};
    rx_if.READ_ENABLE = re_start;
    if (re_start && nbits == 11) begin
      exp_q.push_back({d, model_err(d, par, stp)});
    end
    for (int i = 0; i < nbits; i++) begin
      send_bit(bits[i]);
      if (i == 0) rx_if.READ_ENABLE = re_rest;
    end
    ps2_data = 1'b1;
    wait_cycles(3 * HALF);
    $display("frame sent data=%02h par=%0b stop=%0b bits=%0d re=%0b/%0b",
             d, par, stp, nbits, re_start, re_rest);
  endtask

  always @(negedge clk) begin
    if (prev_ready) begin
      check("strobe_width", {31'd0, rx_if.BYTE_READY}, 32'd0);
    end
    if (rx_if.BYTE_READY) begin
      $display("strobe byte=%02h err=%02b", rx_if.BYTE_READ, rx_if.BYTE_ERROR_CODE);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        exp_item = exp_q.pop_front();
        check("byte_read", {24'd0, rx_if.BYTE_READ}, {24'd0, exp_item.b});
        check("error_code", {30'd0, rx_if.BYTE_ERROR_CODE}, {30'd0, exp_item.e});
      end
    end
    prev_ready <= rx_if.BYTE_READY;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       par;
    logic       stp;
    logic       re;

    rx_if.READ_ENABLE = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("reset_byte",  {24'd0, rx_if.BYTE_READ},       32'd0);
    check("reset_err",   {30'd0, rx_if.BYTE_ERROR_CODE}, 32'd0);
    check("reset_ready", {31'd0, rx_if.BYTE_READY},      32'd0);
    wait_cycles(5);
    rst = 1'b0;
    wait_cycles(10);

    // Good frames, back to back
    send_frame(8'hFA, 1'b1, 1'b1, 11, 1'b1, 1'b1);
    send_frame(8'hAA, 1'b1, 1'b1, 11, 1'b1, 1'b1);
    send_frame(8'h00, 1'b1, 1'b1, 11, 1'b1, 1'b1);
    // Parity / stop errors
    send_frame(8'hAA, 1'b0, 1'b1, 11, 1'b1, 1'b1);
    send_frame(8'h00, 1'b1, 1'b0, 11, 1'b1, 1'b1);
    send_frame(8'h00, 1'b0, 1'b0, 11, 1'b1, 1'b1);
    // Timeout: start + 4 data bits, then silence
    send_frame(8'h0F, 1'b1, 1'b1, 5, 1'b1, 1'b1);
    wait_cycles(TIMEOUT + 10);
    send_frame(8'hF4, 1'b0, 1'b1, 11, 1'b1, 1'b1);
    // Gating
    send_frame(8'hFA, 1'b1, 1'b1, 11, 1'b0, 1'b0);
    send_frame(8'hFA, 1'b1, 1'b1, 11, 1'b1, 1'b0);
    // Reset mid-frame after 5 data bits, outputs first made non-zero
    send_frame(8'hA5, 1'b1, 1'b0, 11, 1'b1, 1'b1);
    send_frame(8'h3C, 1'b1, 1'b1, 6, 1'b1, 1'b1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midreset_byte",  {24'd0, rx_if.BYTE_READ},       32'd0);
    check("midreset_err",   {30'd0, rx_if.BYTE_ERROR_CODE}, 32'd0);
    check("midreset_ready", {31'd0, rx_if.BYTE_READY},      32'd0);
    #23 rst = 1'b0;
    wait_cycles(10);
    send_frame(8'hFA, 1'b1, 1'b1, 11, 1'b1, 1'b1);

    // Randomised frames
    for (int n = 0; n < 20; n++) begin
      d   = 8'($urandom);
      par = ~(^d);
      if ($urandom_range(0, 3) == 0) par = ~par;
      stp = ($urandom_range(0, 4) != 0);
      re  = ($urandom_range(0, 5) != 0);
      send_frame(d, par, stp, 11, re, re);
    end

    wait_cycles(20);
    check("pending_strobes", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
